// File: rtl/onehot_pulse_decoder.sv
// Registered 3-to-8 one-hot pulse decoder: holds the decoded line HOLD_CYC cycles, then GAP_CYC zero cycles.
// Optional walking-one scan of all eight codes is enabled with `define DEC_SCAN_EN.
module onehot_pulse_decoder #(
    parameter int HOLD_CYC = 2,
    parameter int GAP_CYC  = 2,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    input  logic       in_valid,
`ifdef DEC_SCAN_EN
    input  logic       scan_req,
`endif
    output logic       in_ready,
    output logic [7:0] out,
    output logic [2:0] out_code,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic [7:0] decode(input logic [2:0] c);
        decode = 8'b1 << c;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [7:0]       r_out,   w_out_nxt;
    logic [2:0]       r_code,  w_code_nxt;
    logic             r_done,  w_done_nxt;
    logic             w_code_end;
    logic             w_chain;

`ifdef DEC_SCAN_EN
    logic r_scan, w_scan_nxt;
    // A running scan moves straight on to the next code instead of returning to IDLE.
    assign w_chain = r_scan && (r_code != 3'd7);
`else
    assign w_chain = 1'b0;
`endif

    // End of one code's hold+gap window (the hold alone when there is no gap).
    assign w_code_end = (r_cnt == '0) &&
                        ((r_state == S_GAP) || ((r_state == S_HOLD) && (GAP_CYC == 0)));

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_code_nxt  = r_code;
        w_done_nxt  = 1'b0;
`ifdef DEC_SCAN_EN
        w_scan_nxt  = r_scan;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = S_HOLD;
                    w_out_nxt   = decode(code_in);
                    w_code_nxt  = code_in;
                    w_cnt_nxt   = HOLD_LOAD;
                end
`ifdef DEC_SCAN_EN
                else if (scan_req) begin
                    w_state_nxt = S_HOLD;
                    w_out_nxt   = 8'h01;
                    w_code_nxt  = 3'd0;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_scan_nxt  = 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (GAP_CYC > 0) begin
                    w_out_nxt   = 8'h00;
                    w_cnt_nxt   = GAP_LOAD;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_code_end) begin
            if (w_chain) begin
                w_state_nxt = S_HOLD;
                w_out_nxt   = decode(r_code + 3'd1);
                w_code_nxt  = r_code + 3'd1;
                w_cnt_nxt   = HOLD_LOAD;
            end else begin
                w_state_nxt = S_IDLE;
                w_out_nxt   = 8'h00;
                w_done_nxt  = 1'b1;
`ifdef DEC_SCAN_EN
                w_scan_nxt  = 1'b0;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_out   <= 8'h00;
            r_code  <= 3'd0;
            r_done  <= 1'b0;
`ifdef DEC_SCAN_EN
            r_scan  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_code  <= w_code_nxt;
            r_done  <= w_done_nxt;
`ifdef DEC_SCAN_EN
            r_scan  <= w_scan_nxt;
`endif
        end
    end

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign out      = r_out;
    assign out_code = r_code;
    assign done     = r_done;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Scoreboard bench for onehot_pulse_decoder: default DUT (2/2) plus a HOLD_CYC=1, GAP_CYC=0 instance.
module tb_onehot_pulse_decoder;

    localparam int HOLD = 2;
    localparam int GAP  = 2;

    typedef struct packed {
        logic [7:0] val;
        logic [2:0] code;
        logic [7:0] len;
    } pulse_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] code_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic [2:0] out_code;
    logic       busy;
    logic       done;
`ifdef DEC_SCAN_EN
    logic       scan_req;
    logic       b_scan_req;
`endif

    logic [2:0] b_code;
    logic       b_valid;
    logic       b_in_ready;
    logic [7:0] b_out;
    logic [2:0] b_out_code;
    logic       b_busy;
    logic       b_done;

    int n_checks = 0;
    int n_pass   = 0;

    pulse_t q_exp[$];
    pulse_t q_obs[$];

    always #5 clk = ~clk;

    onehot_pulse_decoder #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .code_in  (code_in),
        .in_valid (in_valid),
`ifdef DEC_SCAN_EN
        .scan_req (scan_req),
`endif
        .in_ready (in_ready),
        .out      (out),
        .out_code (out_code),
        .busy     (busy),
        .done     (done)
    );

    onehot_pulse_decoder #(.HOLD_CYC(1), .GAP_CYC(0), .CNT_W(4)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .code_in  (b_code),
        .in_valid (b_valid),
`ifdef DEC_SCAN_EN
        .scan_req (b_scan_req),
`endif
        .in_ready (b_in_ready),
        .out      (b_out),
        .out_code (b_out_code),
        .busy     (b_busy),
        .done     (b_done)
    );

    // Pulse monitor: records each completed non-zero run of out with its code and length.
    logic [7:0] m_prev;
    logic [2:0] m_code;
    int         m_len;
    logic       m_bad_onehot;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_prev = 8'h00;
            m_len  = 0;
            m_code = 3'd0;
        end else begin
            if ($countones(out) > 1 || $countones(b_out) > 1) m_bad_onehot = 1'b1;
            if (out !== m_prev) begin
                if (m_prev != 8'h00) q_obs.push_back('{val: m_prev, code: m_code, len: 8'(m_len)});
                if (out != 8'h00) begin
                    m_len  = 1;
                    m_code = out_code;
                end
                m_prev = out;
            end else if (out != 8'h00) begin
                m_len++;
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || out_code !== 3'd0)
            $display("FAIL reset_state: out=%h busy=%b done=%b in_ready=%b out_code=%0d, required 00 0 0 1 0",
                     out, busy, done, in_ready, out_code);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        code_in  = 3'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (out !== 8'h20) $display("FAIL mid_hold_out: got %h, required 20", out);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out !== 8'h00) $display("FAIL async_rst_out: got %h, required 00", out);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL async_rst_busy_done: got %b%b, required 00", busy, done);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1 || out_code !== 3'd0)
            $display("FAIL async_rst_ready_code: in_ready=%b out_code=%0d, required 1 0", in_ready, out_code);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (q_obs.size() != 0) $display("FAIL aborted_pulse: %0d pulses recorded, required 0", q_obs.size());
        else n_pass++;
    endtask

    task automatic test_single();
        int     n;
        pulse_t e, o;
        @(negedge clk);
        code_in  = 3'd3;
        in_valid = 1'b1;
        q_exp.push_back('{val: 8'h08, code: 3'd3, len: 8'(HOLD)});
        @(negedge clk);
        in_valid = 1'b0;
        code_in  = 3'($urandom);
        n = 1;
        n_checks++;
        if (out !== 8'h08 || busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL single_first_cycle: out=%h busy=%b in_ready=%b, required 08 1 0", out, busy, in_ready);
        else n_pass++;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != HOLD + GAP + 1) $display("FAIL single_done_latency: got %0d cycles, required %0d", n, HOLD + GAP + 1);
        else n_pass++;
        n_checks++;
        if (out !== 8'h00 || out_code !== 3'd3 || in_ready !== 1'b1)
            $display("FAIL single_done_state: out=%h out_code=%0d in_ready=%b, required 00 3 1", out, out_code, in_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) $display("FAIL single_done_width: done=%b one cycle later, required 0", done);
        else n_pass++;
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            n_checks++;
            if (q_obs.size() == 0) $display("FAIL single_pulse: no pulse recorded, required val=%h", e.val);
            else begin
                o = q_obs.pop_front();
                if (o !== e) $display("FAIL single_pulse: got val=%h code=%0d len=%0d, required val=%h code=%0d len=%0d",
                                      o.val, o.code, o.len, e.val, e.code, e.len);
                else n_pass++;
            end
        end
    endtask

    task automatic test_walking();
        int         n;
        logic [7:0] one;
        pulse_t     e, o;
        @(negedge clk);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            code_in = 3'(k);
            one     = 8'h01 << k;
            q_exp.push_back('{val: one, code: 3'(k), len: 8'(HOLD)});
            @(negedge clk);
            n = 1;
            while (in_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            n_checks++;
            if (n != HOLD + GAP + 1 || done !== 1'b1)
                $display("FAIL walking_period code %0d: got %0d cycles done=%b, required %0d cycles done=1",
                         k, n, done, HOLD + GAP + 1);
            else n_pass++;
        end
        in_valid = 1'b0;
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            n_checks++;
            if (q_obs.size() == 0) $display("FAIL walking_pulse: no pulse recorded, required val=%h", e.val);
            else begin
                o = q_obs.pop_front();
                if (o !== e) $display("FAIL walking_pulse: got val=%h code=%0d len=%0d, required val=%h code=%0d len=%0d",
                                      o.val, o.code, o.len, e.val, e.code, e.len);
                else n_pass++;
            end
        end
    endtask

    task automatic test_min_hold_no_gap();
        logic [7:0] one;
        @(negedge clk);
        b_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b_code = 3'(k);
            one    = 8'h01 << k;
            @(negedge clk);
            n_checks++;
            if (b_out !== one || b_in_ready !== 1'b0 || b_done !== 1'b0)
                $display("FAIL b_hold code %0d: out=%h in_ready=%b done=%b, required %h 0 0",
                         k, b_out, b_in_ready, b_done, one);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (b_out !== 8'h00 || b_done !== 1'b1 || b_in_ready !== 1'b1 || b_out_code !== 3'(k))
                $display("FAIL b_idle code %0d: out=%h done=%b in_ready=%b out_code=%0d, required 00 1 1 %0d",
                         k, b_out, b_done, b_in_ready, b_out_code, k);
            else n_pass++;
        end
        b_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) $display("FAIL b_settle: done=%b busy=%b, required 0 0", b_done, b_busy);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic [7:0] want;
        pulse_t     e, o;
        @(negedge clk);
        code_in  = 3'd2;
        in_valid = 1'b1;
        q_exp.push_back('{val: 8'h04, code: 3'd2, len: 8'(HOLD)});
        @(negedge clk);
        for (int i = 0; i < HOLD + GAP; i++) begin
            want = (i < HOLD) ? 8'h04 : 8'h00;
            n_checks++;
            if (out !== want || out_code !== 3'd2 || done !== 1'b0 || busy !== 1'b1)
                $display("FAIL busy_ignore cycle %0d: out=%h out_code=%0d done=%b busy=%b, required %h 2 0 1",
                         i, out, out_code, done, busy, want);
            else n_pass++;
            code_in = (i % 2 == 0) ? 3'd6 : 3'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || in_ready !== 1'b1 || out_code !== 3'd2)
            $display("FAIL busy_ignore_done: done=%b in_ready=%b out_code=%0d, required 1 1 2", done, in_ready, out_code);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL busy_ignore_after: done=%b busy=%b, required 0 0", done, busy);
        else n_pass++;
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            n_checks++;
            if (q_obs.size() == 0) $display("FAIL busy_pulse: no pulse recorded, required val=%h", e.val);
            else begin
                o = q_obs.pop_front();
                if (o !== e) $display("FAIL busy_pulse: got val=%h code=%0d len=%0d, required val=%h code=%0d len=%0d",
                                      o.val, o.code, o.len, e.val, e.code, e.len);
                else n_pass++;
            end
        end
    endtask

`ifdef DEC_SCAN_EN
    task automatic test_scan();
        int         n;
        int         n_done;
        logic       ready_seen;
        logic [7:0] one;
        pulse_t     e, o;
        @(negedge clk);
        scan_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            one = 8'h01 << k;
            q_exp.push_back('{val: one, code: 3'(k), len: 8'(HOLD)});
        end
        @(negedge clk);
        scan_req   = 1'b0;
        n          = 1;
        n_done     = 0;
        ready_seen = 1'b0;
        while (in_ready !== 1'b1 && n < 100) begin
            if (done === 1'b1) n_done++;
            if (busy !== 1'b1) ready_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n != 8 * (HOLD + GAP) + 1 || n_done != 0 || ready_seen)
            $display("FAIL scan_span: got %0d cycles early_done=%0d not_busy=%b, required %0d 0 0",
                     n, n_done, ready_seen, 8 * (HOLD + GAP) + 1);
        else n_pass++;
        n_checks++;
        if (done !== 1'b1 || out_code !== 3'd7) $display("FAIL scan_done: done=%b out_code=%0d, required 1 7", done, out_code);
        else n_pass++;
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            n_checks++;
            if (q_obs.size() == 0) $display("FAIL scan_pulse: no pulse recorded, required val=%h", e.val);
            else begin
                o = q_obs.pop_front();
                if (o !== e) $display("FAIL scan_pulse: got val=%h code=%0d len=%0d, required val=%h code=%0d len=%0d",
                                      o.val, o.code, o.len, e.val, e.code, e.len);
                else n_pass++;
            end
        end
        @(negedge clk);
        scan_req = 1'b1;
        q_exp.push_back('{val: 8'h01, code: 3'd0, len: 8'(HOLD)});
        @(negedge clk);
        scan_req = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL scan_abort: out=%h busy=%b in_ready=%b done=%b, required 00 0 1 0", out, busy, in_ready, done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || out !== 8'h00) $display("FAIL scan_stays_idle: busy=%b out=%h, required 0 00", busy, out);
        else n_pass++;
        while (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            n_checks++;
            if (q_obs.size() == 0) $display("FAIL scan_abort_pulse: no pulse recorded, required val=%h", e.val);
            else begin
                o = q_obs.pop_front();
                if (o !== e) $display("FAIL scan_abort_pulse: got val=%h len=%0d, required val=%h len=%0d",
                                      o.val, o.len, e.val, e.len);
                else n_pass++;
            end
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        code_in      = 3'd0;
        in_valid     = 1'b0;
        b_code       = 3'd0;
        b_valid      = 1'b0;
        m_bad_onehot = 1'b0;
`ifdef DEC_SCAN_EN
        scan_req     = 1'b0;
        b_scan_req   = 1'b0;
`endif
        test_reset();
        test_reset_mid_hold();
        test_single();
        test_walking();
        test_min_hold_no_gap();
        test_busy_ignore();
`ifdef DEC_SCAN_EN
        test_scan();
`endif
        n_checks++;
        if (m_bad_onehot !== 1'b0) $display("FAIL onehot_rule: multiple bits seen set on out");
        else n_pass++;
        n_checks++;
        if (q_obs.size() != 0) $display("FAIL extra_pulses: %0d unexpected pulses, required 0", q_obs.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
